fc_apb_master: RTL and testbench

//   APB initiator used by the FC test/control path to program and poll the FC APB register

---
 rtl/fc_apb_master.sv | 156 +++++++++++++++
 tb/tb_fc_apb_master.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_apb_master.sv
// APB3 initiator for the FC control path: valid/ready command and response ports around one APB transfer.
// Optional ACCESS-phase timeout is enabled by defining APB_TIMEOUT_EN.
module fc_apb_master #(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                  PCLK,
  input  logic                  PRESETB,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  busy,
  output logic [15:0]           txn_count,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [DATA_WIDTH-1:0] pwdata_q, pwdata_d;
  logic                  pwrite_q, pwrite_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;
  logic                  tmo_flag_q, tmo_flag_d;
  logic [15:0]           txn_q, txn_d;
  logic                  tmo_hit;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("fc_apb_master: TIMEOUT_CYCLES must be >= 2");
  end

`ifdef APB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] tmo_q, tmo_d;

  always_ff @(posedge PCLK or negedge PRESETB) begin
    if (!PRESETB) tmo_q <= '0;
    else          tmo_q <= tmo_d;
  end

  // The stall that would bring the count to TIMEOUT_CYCLES ends the transfer.
  always_comb begin
    tmo_d   = tmo_q;
    tmo_hit = 1'b0;
    if (state_q == SETUP) begin
      tmo_d = '0;
    end else if (state_q == ACCESS && !PREADY) begin
      tmo_d = tmo_q + 1'b1;
      if (tmo_q == CW'(TIMEOUT_CYCLES - 1)) tmo_hit = 1'b1;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge PCLK or negedge PRESETB) begin
    if (!PRESETB) begin
      state_q    <= IDLE;
      paddr_q    <= '0;
      pwdata_q   <= '0;
      pwrite_q   <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      tmo_flag_q <= 1'b0;
      txn_q      <= '0;
    end else begin
      state_q    <= state_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
      pwrite_q   <= pwrite_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      tmo_flag_q <= tmo_flag_d;
      txn_q      <= txn_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    pwrite_d   = pwrite_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    tmo_flag_d = tmo_flag_q;
    txn_d      = txn_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
          pwrite_d = cmd_write;
          state_d  = SETUP;
        end
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (PREADY) begin
          rdata_d    = pwrite_q ? '0 : PRDATA;
          err_d      = PSLVERR;
          tmo_flag_d = 1'b0;
          txn_d      = txn_q + 16'd1;
          state_d    = RESP;
        end else if (tmo_hit) begin
          rdata_d    = '0;
          err_d      = 1'b1;
          tmo_flag_d = 1'b1;
          txn_d      = txn_q + 16'd1;
          state_d    = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == IDLE);
    busy      = (state_q != IDLE);
    PSEL      = (state_q == SETUP) || (state_q == ACCESS);
    PENABLE   = (state_q == ACCESS);
    rsp_valid = (state_q == RESP);
  end

  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign PWRITE    = pwrite_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;
  assign txn_count = txn_q;
`ifdef APB_TIMEOUT_EN
  assign rsp_timeout = tmo_flag_q;
`else
  assign rsp_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_fc_apb_master.sv
// Directed bench for fc_apb_master: a small APB slave with programmable wait states plus per-scenario tasks.
module tb_fc_apb_master;

  logic        PCLK = 1'b0;
  logic        PRESETB;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err, rsp_timeout, busy;
  logic [15:0] txn_count;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;

  int total = 0;
  int bad   = 0;

  int unsigned wait_n  = 0;
  bit          stall   = 1'b0;
  int unsigned acc_cnt = 0;

  always #5 PCLK = ~PCLK;

  fc_apb_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(8)) dut (
    .PCLK(PCLK), .PRESETB(PRESETB),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy), .txn_count(txn_count),
    .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  // Slave inserts wait_n not-ready ACCESS cycles, or stalls forever while stall is set.
  assign PREADY = PSEL && PENABLE && !stall && (acc_cnt >= wait_n);
  always @(posedge PCLK) begin
    if (PSEL && PENABLE && !PREADY) acc_cnt <= acc_cnt + 1;
    else                            acc_cnt <= 0;
  end

  task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d, input bit keep);
    @(negedge PCLK);
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    @(negedge PCLK);
    if (!keep) cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int en, output bit addr_moved, input logic [31:0] a, input int limit);
    en = 0;
    addr_moved = 1'b0;
    for (int i = 0; i < limit && !rsp_valid; i++) begin
      if (PENABLE) begin
        en++;
        if (PADDR !== a) addr_moved = 1'b1;
      end
      @(negedge PCLK);
    end
  endtask

  task automatic test_reset;
    PRESETB = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    rsp_ready = 1'b1; PRDATA = '0; PSLVERR = 1'b0;
    repeat (3) @(negedge PCLK);
    total++;
    if ({PSEL, PENABLE, rsp_valid, busy, cmd_ready} !== 5'b00001) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=00001", {PSEL, PENABLE, rsp_valid, busy, cmd_ready});
    end
    total++;
    if ({PADDR, PWDATA, PWRITE, rsp_rdata, rsp_err, rsp_timeout, txn_count} !== '0) begin
      bad++; $display("FAIL reset_regs paddr=%h pwdata=%h rdata=%h txn=%0d exp all zero", PADDR, PWDATA, rsp_rdata, txn_count);
    end
    PRESETB = 1'b1;
  endtask

  task automatic test_write;
    issue(1'b1, 32'h0, 32'h1, 1'b0);
    total++;
    if ({PSEL, PENABLE} !== 2'b10) begin
      bad++; $display("FAIL t1_setup psel_pen=%b exp=10", {PSEL, PENABLE});
    end
    @(negedge PCLK);
    total++;
    if ({PSEL, PENABLE, PWRITE} !== 3'b111 || PADDR !== 32'h0 || PWDATA !== 32'h1) begin
      bad++; $display("FAIL t1_access sel_en_wr=%b paddr=%h pwdata=%h exp 111/0/1", {PSEL, PENABLE, PWRITE}, PADDR, PWDATA);
    end
    @(negedge PCLK);
    total++;
    if ({rsp_valid, rsp_err, PSEL, PENABLE} !== 4'b1000 || rsp_rdata !== 32'h0 || txn_count !== 16'd1) begin
      bad++; $display("FAIL t1_resp v_e_s_en=%b rdata=%h txn=%0d exp 1000/0/1", {rsp_valid, rsp_err, PSEL, PENABLE}, rsp_rdata, txn_count);
    end
    @(negedge PCLK);
    total++;
    if ({busy, rsp_valid, cmd_ready} !== 3'b001) begin
      bad++; $display("FAIL t1_idle busy_v_rdy=%b exp=001", {busy, rsp_valid, cmd_ready});
    end
  endtask

  task automatic test_wait_states;
    int en; bit moved;
    wait_n = 3; PRDATA = 32'h7;
    issue(1'b0, 32'h8, 32'hFFFF_FFFF, 1'b0);
    wait_rsp(en, moved, 32'h8, 20);
    total++;
    if (en != 4 || moved) begin
      bad++; $display("FAIL t2_penable_cycles got=%0d moved=%0d exp=4 moved=0", en, moved);
    end
    total++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h7 || rsp_err !== 1'b0 || txn_count !== 16'd2) begin
      bad++; $display("FAIL t2_resp v=%b rdata=%h err=%b txn=%0d exp 1/7/0/2", rsp_valid, rsp_rdata, rsp_err, txn_count);
    end
    wait_n = 0;
    @(negedge PCLK);
  endtask

  task automatic test_slverr;
    int en; bit moved;
    PRDATA = 32'hDEAD_BEEF; PSLVERR = 1'b1;
    issue(1'b0, 32'h4, 32'h0, 1'b0);
    wait_rsp(en, moved, 32'h4, 20);
    total++;
    if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b110 || rsp_rdata !== 32'hDEAD_BEEF || txn_count !== 16'd3) begin
      bad++; $display("FAIL t3_slverr v_e_t=%b rdata=%h txn=%0d exp 110/deadbeef/3", {rsp_valid, rsp_err, rsp_timeout}, rsp_rdata, txn_count);
    end
    PSLVERR = 1'b0;
    @(negedge PCLK);
  endtask

  task automatic test_backpressure;
    int en; bit moved; bit unstable;
    logic [31:0] r0; logic e0;
    rsp_ready = 1'b0; PRDATA = 32'h1111_2222;
    issue(1'b1, 32'hC, 32'h55, 1'b1);
    cmd_write = 1'b0; cmd_addr = 32'h10; cmd_wdata = 32'h0;
    wait_rsp(en, moved, 32'hC, 20);
    r0 = rsp_rdata; e0 = rsp_err;
    unstable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if ({rsp_valid, cmd_ready, PSEL} !== 3'b100 || rsp_rdata !== r0 || rsp_err !== e0) unstable = 1'b1;
      @(negedge PCLK);
    end
    total++;
    if (unstable || r0 !== 32'h0 || e0 !== 1'b0) begin
      bad++; $display("FAIL t4_hold unstable=%0d rdata=%h err=%b exp 0/0/0", unstable, r0, e0);
    end
    rsp_ready = 1'b1;
    @(negedge PCLK);
    total++;
    if ({cmd_ready, PSEL, rsp_valid} !== 3'b100) begin
      bad++; $display("FAIL t4_bubble rdy_sel_v=%b exp=100", {cmd_ready, PSEL, rsp_valid});
    end
    @(negedge PCLK);
    total++;
    if ({PSEL, PENABLE, PWRITE} !== 3'b100 || PADDR !== 32'h10) begin
      bad++; $display("FAIL t4_next_accept sel_en_wr=%b paddr=%h exp 100/10", {PSEL, PENABLE, PWRITE}, PADDR);
    end
    cmd_valid = 1'b0;
    wait_rsp(en, moved, 32'h10, 20);
    total++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1111_2222 || txn_count !== 16'd5) begin
      bad++; $display("FAIL t4_second v=%b rdata=%h txn=%0d exp 1/11112222/5", rsp_valid, rsp_rdata, txn_count);
    end
    @(negedge PCLK);
  endtask

  task automatic test_reset_mid_access;
    int en; bit moved;
    stall = 1'b1;
    issue(1'b0, 32'h20, 32'h0, 1'b0);
    @(negedge PCLK);
    total++;
    if (PENABLE !== 1'b1) begin
      bad++; $display("FAIL t5_in_access penable=%b exp=1", PENABLE);
    end
    #2 PRESETB = 1'b0;
    #1;
    total++;
    if ({PSEL, PENABLE, rsp_valid, busy} !== 4'b0000 || txn_count !== 16'd0) begin
      bad++; $display("FAIL t5_async_reset sel_en_v_busy=%b txn=%0d exp 0000/0", {PSEL, PENABLE, rsp_valid, busy}, txn_count);
    end
    @(negedge PCLK);
    PRESETB = 1'b1; stall = 1'b0;
    issue(1'b1, 32'h24, 32'hA5, 1'b0);
    wait_rsp(en, moved, 32'h24, 20);
    total++;
    if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rdata !== 32'h0 || txn_count !== 16'd1 || en != 1) begin
      bad++; $display("FAIL t5_after_reset v_e=%b rdata=%h txn=%0d en=%0d exp 10/0/1/1", {rsp_valid, rsp_err}, rsp_rdata, txn_count, en);
    end
    @(negedge PCLK);
  endtask

`ifdef APB_TIMEOUT_EN
  task automatic test_timeout;
    int en; bit moved;
    stall = 1'b1; PRDATA = 32'h9999_9999;
    issue(1'b0, 32'h30, 32'h0, 1'b0);
    wait_rsp(en, moved, 32'h30, 40);
    total++;
    if (en != 8 || rsp_valid !== 1'b1) begin
      bad++; $display("FAIL t6_timeout_len en=%0d v=%b exp 8/1", en, rsp_valid);
    end
    total++;
    if ({rsp_err, rsp_timeout} !== 2'b11 || rsp_rdata !== 32'h0 || txn_count !== 16'd2) begin
      bad++; $display("FAIL t6_timeout_rsp e_t=%b rdata=%h txn=%0d exp 11/0/2", {rsp_err, rsp_timeout}, rsp_rdata, txn_count);
    end
    @(negedge PCLK);
    stall = 1'b0; wait_n = 7;
    issue(1'b0, 32'h34, 32'h0, 1'b0);
    wait_rsp(en, moved, 32'h34, 40);
    total++;
    if (en != 8 || {rsp_valid, rsp_err, rsp_timeout} !== 3'b100 || rsp_rdata !== 32'h9999_9999 || txn_count !== 16'd3) begin
      bad++; $display("FAIL t6_ready_at_limit en=%0d v_e_t=%b rdata=%h txn=%0d exp 8/100/99999999/3", en, {rsp_valid, rsp_err, rsp_timeout}, rsp_rdata, txn_count);
    end
    wait_n = 0;
    @(negedge PCLK);
  endtask
`else
  task automatic test_timeout;
    int en; bit moved; int stuck;
    stall = 1'b1; PRDATA = 32'h0000_1234;
    issue(1'b0, 32'h30, 32'h0, 1'b0);
    @(negedge PCLK);
    stuck = 0;
    for (int i = 0; i < 120; i++) begin
      if (PENABLE && !rsp_valid && !rsp_timeout) stuck++;
      @(negedge PCLK);
    end
    total++;
    if (stuck != 120) begin
      bad++; $display("FAIL t6_no_timeout stuck=%0d exp=120", stuck);
    end
    stall = 1'b0;
    wait_rsp(en, moved, 32'h30, 10);
    total++;
    if ({rsp_valid, rsp_err, rsp_timeout} !== 3'b100 || rsp_rdata !== 32'h0000_1234 || txn_count !== 16'd2) begin
      bad++; $display("FAIL t6_late_ready v_e_t=%b rdata=%h txn=%0d exp 100/1234/2", {rsp_valid, rsp_err, rsp_timeout}, rsp_rdata, txn_count);
    end
    @(negedge PCLK);
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_wait_states();
    test_slverr();
    test_backpressure();
    test_reset_mid_access();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

endmodule
